mulpipe: RTL and testbench

Parametrised pipelined multiply-accumulate unit for the arithmetic library. Registers operands, multiplies them with a per-transaction signed/unsigned mode, carries the product through a configurable number of pipeline stages, and either writes it to the output or adds it to the running output value. A valid bit travels with the data. A sticky overflow flag and a synchronous clear support accumulation use.

---
 rtl/mulpipe.sv | 115 +++++++++++
 tb/tb_mulpipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mulpipe.sv
// rtl/mulpipe.sv - pipelined signed/unsigned multiply-accumulate unit
// Input register, STAGES product registers, then an output accumulator with sticky overflow.
module mulpipe #(
   parameter int DW     = 16,
   parameter int OW     = 32,
   parameter int STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic          sgn,
   input  logic          acc,
   input  logic          clr,
   output logic          out_valid,
   output logic [OW-1:0] out,
   output logic          ovf
);

   logic [DW-1:0] a_r, b_r;
   logic          sgn_r, acc_r, v_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         a_r   <= '0;
         b_r   <= '0;
         sgn_r <= 1'b0;
         acc_r <= 1'b0;
         v_r   <= 1'b0;
      end else begin
         a_r   <= a;
         b_r   <= b;
         sgn_r <= sgn;
         acc_r <= acc;
         v_r   <= in_valid;
      end
   end

   // Operands are extended straight to OW bits: the low OW bits of the
   // product only depend on the low OW bits of the extended operands.
   logic [OW-1:0] ae, be, prod_c;

   generate
      if (OW > DW) begin : g_ext
         assign ae = {{(OW-DW){sgn_r & a_r[DW-1]}}, a_r};
         assign be = {{(OW-DW){sgn_r & b_r[DW-1]}}, b_r};
      end else begin : g_trunc
         assign ae = a_r[OW-1:0];
         assign be = b_r[OW-1:0];
      end
   endgenerate

   assign prod_c = ae * be;

   logic [OW-1:0]     p_q [STAGES];
   logic [STAGES-1:0] s_q, c_q, v_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) p_q[i] <= '0;
         s_q <= '0;
         c_q <= '0;
         v_q <= '0;
      end else begin
         p_q[0] <= prod_c;
         s_q[0] <= sgn_r;
         c_q[0] <= acc_r;
         v_q[0] <= v_r;
         for (int i = 1; i < STAGES; i++) begin
            p_q[i] <= p_q[i-1];
            s_q[i] <= s_q[i-1];
            c_q[i] <= c_q[i-1];
            v_q[i] <= v_q[i-1];
         end
      end
   end

   logic [OW-1:0] p_last;
   logic [OW:0]   sum;
   logic          ov_s, ov_u, ov_hit;

   assign p_last = p_q[STAGES-1];
   assign sum    = {1'b0, out} + {1'b0, p_last};
   assign ov_s   = (out[OW-1] == p_last[OW-1]) && (sum[OW-1] != out[OW-1]);
   assign ov_u   = sum[OW];
   assign ov_hit = s_q[STAGES-1] ? ov_s : ov_u;

   always_ff @(posedge clk) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (v_q[STAGES-1]) begin
         out_valid <= 1'b1;
         if (clr) begin
            // Cleared base: the product lands as-is, whatever acc says.
            out <= p_last;
            ovf <= 1'b0;
         end else if (c_q[STAGES-1]) begin
            out <= sum[OW-1:0];
            ovf <= ovf | ov_hit;
         end else begin
            out <= p_last;
         end
      end else begin
         out_valid <= 1'b0;
         if (clr) begin
            out <= '0;
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mulpipe.sv
// tb/tb_mulpipe.sv - directed scoreboard bench for mulpipe (DW=16, OW=32, STAGES=2)
module tb_mulpipe;

   logic        clk = 1'b0;
   logic        rst, in_valid, sgn, acc, clr;
   logic [15:0] a, b;
   logic        out_valid, ovf;
   logic [31:0] out;

   int tests = 0;
   int fails = 0;

   logic [32:0] sb[$];
   logic [31:0] m_out = '0;
   logic        m_ovf = 1'b0;

   mulpipe #(.DW(16), .OW(32), .STAGES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
      .sgn(sgn), .acc(acc), .clr(clr),
      .out_valid(out_valid), .out(out), .ovf(ovf)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] pmul(input logic [15:0] x, input logic [15:0] y, input logic s);
      longint xx, yy, pp;
      xx = s ? longint'($signed(x)) : longint'(x);
      yy = s ? longint'($signed(y)) : longint'(y);
      pp = xx * yy;
      return pp[31:0];
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // One-cycle transaction; when push is set the model result is queued.
   task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input logic ac, input logic push);
      logic [32:0] sum;
      logic [31:0] p;
      in_valid = 1'b1; a = x; b = y; sgn = s; acc = ac;
      if (push) begin
         p = pmul(x, y, s);
         if (ac) begin
            sum = {1'b0, m_out} + {1'b0, p};
            if (s ? ((m_out[31] == p[31]) && (sum[31] != m_out[31])) : sum[32])
               m_ovf = 1'b1;
            m_out = sum[31:0];
         end else begin
            m_out = p;
         end
         sb.push_back({m_ovf, m_out});
      end
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   always @(negedge clk) begin
      if (out_valid) begin
         logic [32:0] e;
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_out_valid: got out=0x%08h expected no out_valid", out);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            tests++;
            assert ({ovf, out} === e) else begin
               fails++;
               $error("FAIL scoreboard: got ovf=%0b out=0x%08h expected ovf=%0b out=0x%08h",
                      ovf, out, e[32], e[31:0]);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; acc = 1'b0; clr = 1'b0;
      idle(2);
      rst = 1'b0;
      check("reset_out", out, 32'h0);
      check("reset_out_valid", {31'b0, out_valid}, 32'h0);
      check("reset_ovf", {31'b0, ovf}, 32'h0);

      // Signed multiply with exact latency and single-cycle pulse
      drive(16'hFFFD, 16'h0007, 1'b1, 1'b0, 1'b1);
      idle(2);
      check("lat_not_yet", {31'b0, out_valid}, 32'h0);
      cyc();
      check("lat_valid", {31'b0, out_valid}, 32'h1);
      check("signed_out", out, 32'hFFFFFFEB);
      cyc();
      check("pulse_end", {31'b0, out_valid}, 32'h0);
      check("hold_out", out, 32'hFFFFFFEB);

      // Extreme operands back to back
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      drive(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
      drive(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1);
      idle(5);
      check("extreme_last", out, 32'hC0008000);

      // Accumulate stream after clear
      clr = 1'b1; cyc(); clr = 1'b0;
      m_out = '0; m_ovf = 1'b0;
      check("clr_out", out, 32'h0);
      for (int i = 0; i < 4; i++) drive(16'd2, 16'd3, 1'b1, 1'b1, 1'b1);
      idle(1);
      check("stream_valid", {31'b0, out_valid}, 32'h1);
      idle(4);
      check("stream_sum", out, 32'd24);
      check("stream_ovf", {31'b0, ovf}, 32'h0);

      // Unsigned overflow, sticky through acc=0, then clear
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1);
      drive(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      drive(16'd2, 16'd3, 1'b1, 1'b0, 1'b1);
      idle(5);
      check("ovf_sticky", {31'b0, ovf}, 32'h1);
      check("ovf_out", out, 32'd6);
      clr = 1'b1; cyc(); clr = 1'b0;
      m_out = '0; m_ovf = 1'b0;
      check("clr2_out", out, 32'h0);
      check("clr2_ovf", {31'b0, ovf}, 32'h0);

      // clr coincident with a final-stage accumulate while out=100
      drive(16'd10, 16'd10, 1'b1, 1'b0, 1'b1);
      idle(5);
      check("base_100", out, 32'd100);
      drive(16'd5, 16'd5, 1'b1, 1'b1, 1'b0);
      sb.push_back({1'b0, 32'd25});
      m_out = 32'd25;
      idle(2);
      clr = 1'b1; cyc(); clr = 1'b0;
      check("clr_coinc_valid", {31'b0, out_valid}, 32'h1);
      check("clr_coinc_out", out, 32'd25);
      idle(3);

      // Reset with two transactions in flight
      drive(16'd7, 16'd7, 1'b1, 1'b0, 1'b0);
      drive(16'd9, 16'd9, 1'b1, 1'b0, 1'b0);
      rst = 1'b1; clr = 1'b1; cyc(); rst = 1'b0; clr = 1'b0;
      m_out = '0; m_ovf = 1'b0;
      check("rst_mid_out", out, 32'h0);
      check("rst_mid_ovf", {31'b0, ovf}, 32'h0);
      idle(1);
      drive(16'd4, 16'd4, 1'b0, 1'b0, 1'b1);
      idle(2);
      check("post_rst_not_yet", {31'b0, out_valid}, 32'h0);
      cyc();
      check("post_rst_valid", {31'b0, out_valid}, 32'h1);
      check("post_rst_out", out, 32'd16);
      idle(4);

      check("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      fails++;
      $display("FAIL timeout: got no finish expected finish before 100000");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
